// File: rtl/puf_response_collector_if.sv
// Signal bundle between a collection controller and the PUF response collector.
// The master side requests runs and models the PUF; the slave side is the collector.
interface puf_response_collector_if;
  logic        start;
  logic [7:0]  seed;
  logic [3:0]  n_bits;
  logic [7:0]  chal_out;
  logic        eval_req;
  logic        puf_valid;
  logic        puf_bit;
  logic [15:0] resp_word;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport master (
    output start, seed, n_bits, puf_valid, puf_bit,
    input  chal_out, eval_req, resp_word, busy, done, timeout_err
  );

  modport slave (
    input  start, seed, n_bits, puf_valid, puf_bit,
    output chal_out, eval_req, resp_word, busy, done, timeout_err
  );
endinterface

// File: rtl/puf_response_collector.sv
// Collects up to 16 PUF response bits, each resolved by a 3-way majority vote,
// stepping the challenge through an 8-bit Fibonacci LFSR between bits.
module puf_response_collector (
  input  logic                   clk,
  input  logic                   rst,
  puf_response_collector_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACCUM = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  count;
  logic [3:0]  index;
  logic [1:0]  eval_cnt;
  logic [1:0]  ones_cnt;
  logic [7:0]  wait_cnt;
  logic [7:0]  chal;
  logic [15:0] resp;
  logic        timeout;

  logic        last_eval;
  logic        last_bit;
  logic        wait_expired;
  logic [7:0]  chal_step;

  // eval_cnt counts completed evaluations, so a valid seen at 2 is the third one
  assign last_eval    = (eval_cnt == 2'd2);
  assign last_bit     = ({1'b0, index} == (count - 5'd1));
  assign wait_expired = (wait_cnt == 8'hFF) && !bus.puf_valid;
  assign chal_step    = {chal[6:0], chal[7] ^ chal[5] ^ chal[4] ^ chal[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.puf_valid) begin
          state_next = last_eval ? ACCUM : ISSUE;
        end else if (wait_expired) begin
          state_next = DONE;
        end
      end
      ACCUM: begin
        state_next = last_bit ? DONE : ISSUE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.eval_req    = (state == ISSUE);
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.chal_out    = chal;
    bus.resp_word   = resp;
    bus.timeout_err = timeout;
  end

  // Datapath; everything holds outside the state that owns it, so results persist in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 5'd0;
      index    <= 4'd0;
      eval_cnt <= 2'd0;
      ones_cnt <= 2'd0;
      wait_cnt <= 8'd0;
      chal     <= 8'h00;
      resp     <= 16'h0000;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count    <= (bus.n_bits == 4'd0) ? 5'd16 : {1'b0, bus.n_bits};
            chal     <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
            resp     <= 16'h0000;
            timeout  <= 1'b0;
            index    <= 4'd0;
            eval_cnt <= 2'd0;
            ones_cnt <= 2'd0;
            wait_cnt <= 8'd0;
          end
        end
        ISSUE: begin
          wait_cnt <= 8'd0;
        end
        WAIT: begin
          if (bus.puf_valid) begin
            ones_cnt <= ones_cnt + {1'b0, bus.puf_bit};
            eval_cnt <= eval_cnt + 2'd1;
          end else if (wait_cnt == 8'hFF) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ACCUM: begin
          resp[index] <= (ones_cnt >= 2'd2);
          eval_cnt    <= 2'd0;
          ones_cnt    <= 2'd0;
          index       <= index + 4'd1;
          chal        <= chal_step;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a collection run; sampled only in IDLE.
REQ-004 SHALL have port seed, input, 8 bits: first challenge; sampled with an accepted start.
REQ-005 SHALL have port n_bits, input, 4 bits: response bits to collect, 1..15; 0 means 16; sampled with an accepted start.
REQ-006 SHALL have port chal_out, output, 8 bits: challenge presented to the PUF.
REQ-007 SHALL have port eval_req, output, 1 bit: one-cycle pulse requesting one PUF evaluation.
REQ-008 SHALL have port puf_valid, input, 1 bit: the PUF evaluation result is valid.
REQ-009 SHALL have port puf_bit, input, 1 bit: PUF response bit, qualified by puf_valid.
REQ-010 SHALL have port resp_word, output, 16 bits: collected response, bit i at resp_word[i].
REQ-011 SHALL have port busy, output, 1 bit: high from the cycle after start acceptance through the DONE cycle.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at run end, on success or timeout.
REQ-013 SHALL have port timeout_err, output, 1 bit: sticky flag; last run aborted on timeout.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, ACCUM, DONE.
REQ-015 IDLE with start=1 SHALL perform all of the following:
- latch n_bits.
- load chal_out with seed, or 8'h01 if seed=0.
- clear resp_word, timeout_err, bit index, eval count and ones count.
- go to ISSUE.
REQ-016 start while busy SHALL be ignored.
REQ-017 ISSUE SHALL assert eval_req for exactly that cycle, clear the wait counter and go to WAIT.
REQ-018 chal_out SHALL remain stable from ISSUE until the ACCUM cycle of the same bit.
REQ-019 WAIT with puf_valid=1 SHALL add puf_bit to the ones count and increment the eval count.
REQ-020 After a valid in WAIT, the FSM SHALL go to ISSUE if fewer than 3 evaluations are complete for the bit, else to ACCUM.
REQ-021 puf_valid in any state other than WAIT, including the ISSUE cycle, SHALL be ignored.
REQ-022 WAIT SHALL increment an 8-bit wait counter each cycle without puf_valid.
REQ-023 A cycle in WAIT with the wait counter at 255 and puf_valid=0 SHALL perform all of the following:
- set timeout_err.
- keep the resp_word bits resolved so far.
- go to DONE.
REQ-024 ACCUM SHALL write resp_word[index] = 1 if ones count >= 2 (majority of 3), else 0.
REQ-025 ACCUM SHALL then clear the eval and ones counts and increment the index.
REQ-026 ACCUM SHALL advance chal_out as Fibonacci LFSR: next = {chal_out[6:0], chal_out[7]^chal_out[5]^chal_out[4]^chal_out[3]}.
REQ-027 ACCUM SHALL go to DONE when the written index equals latched count-1, else to ISSUE.
REQ-028 DONE SHALL assert done for one cycle, then return to IDLE; busy SHALL deassert on entry to IDLE.
REQ-029 resp_word, chal_out and timeout_err SHALL hold their values in IDLE until the next accepted start.
REQ-030 With puf_valid returned in the first WAIT cycle, each bit SHALL take 7 cycles and done SHALL assert 7N+1 cycles after busy rises (N = latched count).

Reset
REQ-031 rst=1 SHALL immediately, without a clock edge, force the FSM to IDLE.
REQ-032 rst=1 SHALL immediately force busy=0, done=0, eval_req=0, timeout_err=0, resp_word=16'h0000, chal_out=8'h00 and all counters to 0.
REQ-033 rst asserted mid-run SHALL abort the run, with no done pulse on or after release.

Verification
REQ-034 seed=8'h01, n_bits=4, PUF answers valid with bit=1 in the first WAIT cycle -> resp_word=16'h000F, done 29 cycles after busy rises, 12 eval_req pulses, chal_out sequence 01,02,04,08.
REQ-035 n_bits=1, responses 1,0,1 -> resp_word[0]=1; responses 0,0,1 -> resp_word[0]=0.
REQ-036 n_bits=0, all responses 0 -> 16 bits collected, resp_word=16'h0000, done after 113 busy cycles.
REQ-037 puf_valid never asserted -> timeout_err=1 and done pulse 258 cycles after the first eval_req; busy low next cycle.
REQ-038 seed=8'h00 -> first chal_out=8'h01; start pulsed while busy -> no restart and no change in done timing.
REQ-039 rst pulsed during WAIT of bit 2 -> all outputs zero at once; a new start afterwards completes normally.
